// File: rtl/ts_pkg.sv
// ----------------------------------------------------------------------------
// ts_pkg
// Shared definitions for the transmission-selection slice:
//   - tx_state_t : selector FSM states (ST_IDLE, ST_XMIT, ST_GAP)
//   - DEFAULT_*  : default parameter values for the selector
//   - idx_width  : width of a queue index, never narrower than one bit
// ----------------------------------------------------------------------------
package ts_pkg;

  localparam int DEFAULT_NUM_QUEUES = 4;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_IFG        = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XMIT = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_t;

  // A single-queue build still needs a one-bit index port
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ts_prio_encoder.sv
// ----------------------------------------------------------------------------
// ts_prio_encoder
// Purely combinational strict-priority encoder; the highest set index wins.
// Ports:
//   req     in   NUM_QUEUES          request vector, bit NUM_QUEUES-1 = highest priority
//   req_any out  1                   at least one request present
//   idx     out  idx_width(NUM_QUEUES)  index of the highest set request (0 if none)
// ----------------------------------------------------------------------------
module ts_prio_encoder
  import ts_pkg::*;
#(
  parameter int NUM_QUEUES = DEFAULT_NUM_QUEUES
) (
  input  logic [NUM_QUEUES-1:0]            req,
  output logic                             req_any,
  output logic [idx_width(NUM_QUEUES)-1:0] idx
);

  localparam int QW = idx_width(NUM_QUEUES);

  // Scan upward so a later (higher) set bit overwrites any lower one
  always_comb begin
    req_any = |req;
    idx     = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (req[i]) begin
        idx = QW'(i);
      end
    end
  end

endmodule

// File: rtl/ts_tx_selector.sv
// ----------------------------------------------------------------------------
// ts_tx_selector
// 802.1Q transmission selection. Picks the highest-priority queue that has
// data and shaper eligibility, forwards one whole frame from it to the MAC,
// then enforces an inter-frame gap before choosing again.
// Ports:
//   axis_aclk      in   1                      clock
//   axis_resetn    in   1                      asynchronous active-low reset
//   s_q_tdata      in   NUM_QUEUES*DATA_WIDTH  queue i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_q_tvalid     in   NUM_QUEUES             per-queue tvalid
//   s_q_tlast      in   NUM_QUEUES             per-queue tlast
//   s_q_eligible   in   NUM_QUEUES             per-queue shaper eligibility
//   s_q_tready     out  NUM_QUEUES             per-queue tready (only the selected queue)
//   m_axis_tdata   out  DATA_WIDTH             byte stream to the MAC
//   m_axis_tvalid  out  1
//   m_axis_tlast   out  1
//   m_axis_tready  in   1                      MAC backpressure
//   tx_busy        out  1                      high while transmitting or in the gap
//   cur_queue      out  idx_width(NUM_QUEUES)  last selected queue
// ----------------------------------------------------------------------------
module ts_tx_selector
  import ts_pkg::*;
#(
  parameter int NUM_QUEUES = DEFAULT_NUM_QUEUES,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int IFG_CYCLES = DEFAULT_IFG
) (
  input  logic                             axis_aclk,
  input  logic                             axis_resetn,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] s_q_tdata,
  input  logic [NUM_QUEUES-1:0]            s_q_tvalid,
  input  logic [NUM_QUEUES-1:0]            s_q_tlast,
  input  logic [NUM_QUEUES-1:0]            s_q_eligible,
  output logic [NUM_QUEUES-1:0]            s_q_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_tready,
  output logic                             tx_busy,
  output logic [idx_width(NUM_QUEUES)-1:0] cur_queue
);

  localparam int             QW       = idx_width(NUM_QUEUES);
  localparam int             GW       = $clog2(IFG_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_LOAD = GW'(IFG_CYCLES - 1);

  tx_state_t             state;
  logic [GW-1:0]         gap_cnt;
  logic [NUM_QUEUES-1:0] req;
  logic                  req_any;
  logic [QW-1:0]         win_idx;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic                  sel_tvalid;
  logic                  sel_tlast;

  // Eligibility only matters here, where a new frame is chosen; once a frame
  // is under way the shaper's view is ignored so the frame is never split.
  assign req = s_q_tvalid & s_q_eligible;

  ts_prio_encoder #(
    .NUM_QUEUES(NUM_QUEUES)
  ) u_prio (
    .req     (req),
    .req_any (req_any),
    .idx     (win_idx)
  );

  // Pick out the currently selected queue's beat
  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      if (cur_queue == QW'(i)) begin
        sel_tdata  = s_q_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tvalid = s_q_tvalid[i];
        sel_tlast  = s_q_tlast[i];
      end
    end
  end

  // Pass-through only while transmitting; everything is quiet otherwise, so
  // an async reset forces the outputs to zero straight away via the state.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_q_tready    = '0;
    if (state == ST_XMIT) begin
      m_axis_tdata  = sel_tdata;
      m_axis_tvalid = sel_tvalid;
      m_axis_tlast  = sel_tlast;
      for (int i = 0; i < NUM_QUEUES; i++) begin
        s_q_tready[i] = m_axis_tready && (cur_queue == QW'(i));
      end
    end
  end

  // Selection FSM. IDLE spends one cycle registering the winner, XMIT stays
  // put through underruns and backpressure until the tlast beat moves, and
  // GAP counts IFG_CYCLES idle cycles (loaded with IFG-1, exits at zero).
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state     <= ST_IDLE;
      cur_queue <= '0;
      gap_cnt   <= '0;
      tx_busy   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_any) begin
            cur_queue <= win_idx;
            state     <= ST_XMIT;
            tx_busy   <= 1'b1;
          end
        end
        ST_XMIT: begin
          if (sel_tvalid && m_axis_tready && sel_tlast) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ts_tx_selector.sv
// ----------------------------------------------------------------------------
// tb_ts_tx_selector
// Drives per-queue frame sources into ts_tx_selector, predicts every cycle's
// outputs from a timestamp-based model of the selection rules, and compares
// them in a separate monitor process through an expectation queue.
// ----------------------------------------------------------------------------
module tb_ts_tx_selector;

  import ts_pkg::*;

  localparam int NQ  = 4;
  localparam int DW  = 8;
  localparam int IFG = 12;
  localparam int QW  = 2;

  logic               axis_aclk = 1'b0;
  logic               axis_resetn;
  logic [NQ*DW-1:0]   s_q_tdata;
  logic [NQ-1:0]      s_q_tvalid;
  logic [NQ-1:0]      s_q_tlast;
  logic [NQ-1:0]      s_q_eligible;
  logic [NQ-1:0]      s_q_tready;
  logic [DW-1:0]      m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tlast;
  logic               m_axis_tready;
  logic               tx_busy;
  logic [QW-1:0]      cur_queue;

  ts_tx_selector #(
    .NUM_QUEUES(NQ),
    .DATA_WIDTH(DW),
    .IFG_CYCLES(IFG)
  ) dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_q_tdata     (s_q_tdata),
    .s_q_tvalid    (s_q_tvalid),
    .s_q_tlast     (s_q_tlast),
    .s_q_eligible  (s_q_eligible),
    .s_q_tready    (s_q_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .tx_busy       (tx_busy),
    .cur_queue     (cur_queue)
  );

  always #5 axis_aclk = ~axis_aclk;

  // Expected outputs for one clock cycle
  typedef struct {
    int            cyc;
    bit            busy;
    bit            xmit;
    bit            tvalid;
    bit            tlast;
    logic [DW-1:0] data;
    logic [NQ-1:0] tready;
    logic [QW-1:0] cur;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW:0]   src_q[NQ][$];

  // Stimulus knobs set by the scenario sequence
  int            ready_pct = 100;
  int            valid_pct = 100;
  logic [NQ-1:0] elig_ctl  = '1;
  bit            rst_event = 1'b0;

  // Reference model: a frame in flight plus the first cycle a new pick may happen
  bit            m_sending = 1'b0;
  int            m_q       = 0;
  int            m_resume  = 0;
  logic [QW-1:0] m_cur     = '0;
  int            cyc       = 0;

  // Statistics gathered by the monitor
  int            checks = 0;
  int            errors = 0;
  int            out_beats = 0;
  int            out_sum = 0;
  int            busy_cnt = 0;
  int            stall_cnt = 0;
  int            last_idle_between = -1;
  int            first_q = -1;
  int            exp_beats = 0;
  int            exp_sum = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [NQ-1:0] vld, input logic [NQ-1:0] lst,
                               input logic [NQ*DW-1:0] dat, input logic rdy,
                               input logic [NQ-1:0] elig);
    s_q_tvalid    = vld;
    s_q_tlast     = lst;
    s_q_tdata     = dat;
    m_axis_tready = rdy;
    s_q_eligible  = elig;
  endtask

  task automatic loadFrame(input int q, input int len, input logic [DW-1:0] base);
    logic [DW-1:0] b;
    for (int k = 0; k < len; k++) begin
      b = base + DW'(k);
      src_q[q].push_back({(k == len - 1), b});
      exp_beats++;
      exp_sum += int'(b);
    end
  endtask

  function automatic bit srcEmpty();
    for (int q = 0; q < NQ; q++)
      if (src_q[q].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clearStats();
    out_beats = 0; out_sum = 0; busy_cnt = 0; stall_cnt = 0;
    first_q = -1; exp_beats = 0; exp_sum = 0;
  endtask

  task automatic waitIdle(input int max_cyc);
    int n = 0;
    while (!(srcEmpty() && !m_sending && cyc >= m_resume) && n < max_cyc) begin
      @(negedge axis_aclk);
      n++;
    end
    checkOutput("drain_within_budget", 32'(n < max_cyc), 32'd1);
    repeat (2) @(negedge axis_aclk);
  endtask

  task automatic waitBeats(input int nb, input int max_cyc);
    int n = 0;
    while (out_beats < nb && n < max_cyc) begin
      @(negedge axis_aclk);
      n++;
    end
    checkOutput("beats_within_budget", 32'(n < max_cyc), 32'd1);
  endtask

  // Driver + reference model: one stimulus cycle per clock, expectation pushed
  initial begin : driver
    logic [NQ-1:0]    vld, lst, elig, req;
    logic [NQ*DW-1:0] dat;
    logic [DW-1:0]    d;
    logic             rdy;
    exp_t             e;
    applyStimulus('0, '0, '0, 1'b0, '0);
    forever begin
      @(posedge axis_aclk);
      #1;
      cyc++;
      if (!axis_resetn || rst_event) begin
        m_sending = 1'b0; m_q = 0; m_resume = 0; m_cur = '0; rst_event = 1'b0;
        for (int q = 0; q < NQ; q++) src_q[q].delete();
      end
      elig = elig_ctl;
      for (int q = 0; q < NQ; q++) begin
        vld[q] = (src_q[q].size() > 0) && ($urandom_range(0, 99) < valid_pct);
        if (vld[q]) begin
          {lst[q], d} = src_q[q][0];
        end else begin
          lst[q] = 1'b0;
          d      = DW'($urandom);
        end
        dat[q*DW +: DW] = d;
      end
      rdy = ($urandom_range(0, 99) < ready_pct);
      applyStimulus(vld, lst, dat, rdy, elig);

      e.cyc    = cyc;
      e.xmit   = m_sending;
      e.busy   = m_sending || (cyc < m_resume);
      e.tvalid = m_sending && vld[m_q];
      e.tlast  = m_sending && lst[m_q];
      e.data   = m_sending ? dat[m_q*DW +: DW] : '0;
      e.tready = '0;
      if (m_sending && rdy) e.tready[m_q] = 1'b1;
      e.cur    = m_cur;
      exp_q.push_back(e);

      if (axis_resetn) begin
        if (m_sending) begin
          if (vld[m_q] && rdy && lst[m_q]) begin
            m_sending = 1'b0;
            m_resume  = cyc + 1 + IFG;
          end
        end else if (cyc >= m_resume) begin
          req = vld & elig;
          if (req != '0) begin
            for (int q = 0; q < NQ; q++)
              if (req[q]) m_q = q;
            m_cur     = QW'(m_q);
            m_sending = 1'b1;
          end
        end
      end

      @(negedge axis_aclk);
      for (int q = 0; q < NQ; q++)
        if (vld[q] && s_q_tready[q] === 1'b1 && src_q[q].size() > 0) void'(src_q[q].pop_front());
    end
  end

  // Monitor: pops one expectation per cycle and compares mid-cycle
  initial begin : monitor
    exp_t e;
    bit   frame_open = 1'b0;
    bit   have_tlast = 1'b0;
    int   tlast_cyc  = 0;
    forever begin
      @(negedge axis_aclk);
      if (exp_q.size() == 0) continue;
      e = exp_q.pop_front();
      if (!axis_resetn) begin
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tdata",  32'(m_axis_tdata),  32'd0);
        checkOutput("rst_tready", 32'(s_q_tready),    32'd0);
        checkOutput("rst_busy",   32'(tx_busy),       32'd0);
        frame_open = 1'b0;
        have_tlast = 1'b0;
        continue;
      end
      checkOutput("tx_busy",    32'(tx_busy),       32'(e.busy));
      checkOutput("tvalid",     32'(m_axis_tvalid), 32'(e.tvalid));
      checkOutput("s_q_tready", 32'(s_q_tready),    32'(e.tready));
      checkOutput("cur_queue",  32'(cur_queue),     32'(e.cur));
      if (e.tvalid) begin
        checkOutput("tdata", 32'(m_axis_tdata), 32'(e.data));
        checkOutput("tlast", 32'(m_axis_tlast), 32'(e.tlast));
      end else if (!e.xmit) begin
        checkOutput("idle_tdata", 32'(m_axis_tdata), 32'd0);
      end

      if (tx_busy) busy_cnt++;
      if (m_axis_tvalid && m_axis_tready) begin
        if (!frame_open) begin
          if (have_tlast) last_idle_between = e.cyc - tlast_cyc - 1;
          if (first_q < 0) first_q = int'(cur_queue);
          frame_open = 1'b1;
        end
        out_beats++;
        out_sum += int'(m_axis_tdata);
        if (m_axis_tlast) begin
          frame_open = 1'b0;
          have_tlast = 1'b1;
          tlast_cyc  = e.cyc;
        end
      end else if (frame_open) begin
        stall_cnt++;
      end
    end
  end

  // Scenario sequence
  initial begin : scenarios
    axis_resetn = 1'b0;
    repeat (4) @(negedge axis_aclk);
    #2 axis_resetn = 1'b1;
    @(negedge axis_aclk);
    checkOutput("reset_cur_queue", 32'(cur_queue), 32'd0);
    checkOutput("reset_busy",      32'(tx_busy),   32'd0);

    $display("[TB] single frame on queue 0");
    clearStats();
    loadFrame(0, 4, 8'hA1);
    waitIdle(200);
    checkOutput("s1_beats",       32'(out_beats), 32'd4);
    checkOutput("s1_sum",         32'(out_sum),   32'(exp_sum));
    checkOutput("s1_busy_cycles", 32'(busy_cnt),  32'(4 + IFG));

    $display("[TB] queues 1 and 3 contend");
    clearStats();
    loadFrame(1, 5, 8'h10);
    loadFrame(3, 5, 8'h30);
    waitIdle(300);
    checkOutput("s2_first_queue", 32'(first_q),           32'd3);
    checkOutput("s2_beats",       32'(out_beats),         32'(exp_beats));
    checkOutput("s2_gap",         32'(last_idle_between), 32'(IFG + 1));

    $display("[TB] eligibility dropped mid-frame");
    clearStats();
    loadFrame(2, 6, 8'h20);
    waitBeats(2, 100);
    elig_ctl[2] = 1'b0;
    loadFrame(3, 3, 8'h38);
    waitIdle(300);
    elig_ctl = '1;
    checkOutput("s3_first_queue", 32'(first_q),           32'd2);
    checkOutput("s3_beats",       32'(out_beats),         32'(exp_beats));
    checkOutput("s3_no_stall",    32'(stall_cnt),         32'd0);
    checkOutput("s3_gap",         32'(last_idle_between), 32'(IFG + 1));

    $display("[TB] MAC backpressure");
    clearStats();
    loadFrame(0, 8, 8'h40);
    waitBeats(2, 100);
    ready_pct = 0;
    repeat (3) @(negedge axis_aclk);
    ready_pct = 100;
    waitIdle(300);
    checkOutput("s4_beats", 32'(out_beats), 32'(exp_beats));
    checkOutput("s4_sum",   32'(out_sum),   32'(exp_sum));
    checkOutput("s4_stall", 32'(stall_cnt), 32'd3);

    $display("[TB] ineligible queue holding data");
    clearStats();
    elig_ctl = 4'b1110;
    loadFrame(0, 3, 8'h50);
    repeat (50) @(negedge axis_aclk);
    checkOutput("s5_no_beats", 32'(out_beats), 32'd0);
    checkOutput("s5_not_busy", 32'(busy_cnt),  32'd0);
    elig_ctl = '1;
    waitIdle(300);
    checkOutput("s5_beats", 32'(out_beats), 32'(exp_beats));

    $display("[TB] reset mid-frame");
    clearStats();
    loadFrame(1, 8, 8'h60);
    waitBeats(2, 100);
    @(posedge axis_aclk);
    #3;
    checkOutput("s6_beat3_valid", 32'(m_axis_tvalid), 32'd1);
    axis_resetn = 1'b0;
    rst_event   = 1'b1;
    #1;
    checkOutput("s6_async_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("s6_async_tlast",  32'(m_axis_tlast),  32'd0);
    checkOutput("s6_async_tdata",  32'(m_axis_tdata),  32'd0);
    checkOutput("s6_async_tready", 32'(s_q_tready),    32'd0);
    checkOutput("s6_async_busy",   32'(tx_busy),       32'd0);
    checkOutput("s6_async_cur",    32'(cur_queue),     32'd0);
    repeat (2) @(negedge axis_aclk);
    #2 axis_resetn = 1'b1;
    @(negedge axis_aclk);
    checkOutput("s6_after_cur",  32'(cur_queue), 32'd0);
    checkOutput("s6_after_busy", 32'(tx_busy),   32'd0);

    $display("[TB] randomized traffic");
    clearStats();
    ready_pct = 70;
    valid_pct = 80;
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) < 12)
        loadFrame($urandom_range(0, NQ - 1), $urandom_range(1, 8), DW'($urandom));
      if ($urandom_range(0, 99) < 5)
        elig_ctl = NQ'($urandom);
      @(negedge axis_aclk);
    end
    elig_ctl  = '1;
    ready_pct = 100;
    valid_pct = 100;
    waitIdle(5000);
    checkOutput("s7_beats", 32'(out_beats), 32'(exp_beats));
    checkOutput("s7_sum",   32'(out_sum),   32'(exp_sum));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case something wedges outside the bounded waits
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
